muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit, run beside the ALU in the EX stage. On start it

---
 rtl/muldiv_sequencer_pkg.sv | 16 +
 rtl/muldiv_sequencer.sv | 97 +++++++++
 tb/tb_muldiv_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: RV32M op encodings, sequencer states and decoder constants
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_type;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_SIGN, MD_DONE} md_state_type;
  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide, one bit per cycle, stalls EX until done
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  md_state_type    state;
  md_op_type       op_q;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [XLEN-1:0] opnd, mag_a, mag_b, fast_res, quo_s, rem_s, sign_res;
  logic [CW-1:0]   counter;
  logic            neg, neg_in, a_sgn, b_sgn, neg_a, neg_b, div_zero, ovf, fast, div_ge;
  logic [XLEN:0]   mul_sum, div_rem, div_diff;
  always_comb begin
    a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn    = op[2] ? ~op[0] : ~op[1];
    neg_a    = a_sgn & operand_a[XLEN-1];
    neg_b    = b_sgn & operand_b[XLEN-1];
    mag_a    = neg_a ? -operand_a : operand_a;
    mag_b    = neg_b ? -operand_b : operand_b;
    div_zero = op[2] & (operand_b == '0);
    ovf      = op[2] & ~op[0] & (operand_a == MIN_INT) & (&operand_b);
    fast     = div_zero | ovf;
    fast_res = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_INT);
    // remainder follows the dividend only; quotient and product follow both signs
    neg_in   = (op[2] & op[1]) ? neg_a : neg_a ^ neg_b;
  end
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_rem  = acc[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, opnd};
    div_ge   = ~div_diff[XLEN];
    acc_next = op_q[2] ? (div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0})
                       : {mul_sum, acc[XLEN-1:1]};
    prod     = neg ? -acc : acc;
    quo_s    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s    = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    sign_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                       : (op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      op_q    <= MD_MUL;
      acc     <= '0;
      opnd    <= '0;
      counter <= '0;
      neg     <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          op_q    <= md_op_type'(op);
          neg     <= neg_in;
          counter <= CW'(XLEN);
          if (fast) begin
            result <= fast_res;
            state  <= MD_DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
            opnd  <= op[2] ? mag_b : mag_a;
            state <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc     <= acc_next;
          counter <= counter - 1'b1;
          if (counter == CW'(1)) state <= MD_SIGN;
        end
        MD_SIGN: begin
          result <= sign_res;
          state  <= MD_DONE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
  assign stall        = (state == MD_IDLE & start & ~flush) | state == MD_CALC | state == MD_SIGN;
  assign busy         = state != MD_IDLE;
  assign result_valid = state == MD_DONE;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table plus scoreboard checks for the RV32M sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  typedef struct {
    md_op_type   op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, flush = 0;
  logic [2:0] op = '0;
  logic [31:0] operand_a = '0, operand_b = '0, result;
  logic stall, busy, result_valid;
  int n_chk = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp;
  string cur_name = "reset";
  vec_t tv[18];
  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .operand_a(operand_a),
    .operand_b(operand_b), .flush(flush), .stall(stall), .busy(busy),
    .result_valid(result_valid), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h expected %h", n, cur_name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("result", result, sb.pop_front());
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input md_op_type o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    start = 1;
    op = o;
    operand_a = a;
    operand_b = b;
    if (push) sb.push_back(exp);
    #1;
  endtask
  task automatic wait_valid(input int lat);
    int cyc = 0;
    bit st_ok = 1;
    while (result_valid !== 1'b1 && cyc < 60) begin
      if (stall !== 1'b1) st_ok = 0;
      tick();
      cyc++;
      operand_a = $urandom;
      operand_b = $urandom;
    end
    check("latency", cyc, lat);
    check("stall_while_busy", {31'd0, st_ok}, 32'd1);
    check("stall_in_done", {31'd0, stall}, 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd1);
  endtask
  initial begin
    tv[0]  = '{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    tv[1]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    tv[2]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
    tv[3]  = '{MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    tv[4]  = '{MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    tv[5]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       34};
    tv[6]  = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tv[7]  = '{MD_REMU,   32'd5,        32'd0,        32'd5,        1};
    tv[8]  = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tv[9]  = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    tv[10] = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    tv[11] = '{MD_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34};
    tv[12] = '{MD_REMU,   32'd100,      32'd7,        32'd2,        34};
    tv[13] = '{MD_DIV,    32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 34};
    tv[14] = '{MD_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1};
    tv[15] = '{MD_REMU,   32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 34};
    tv[16] = '{MD_MULHSU, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 34};
    tv[17] = '{MD_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    repeat (3) tick();
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 0;
    tick();
    foreach (tv[i]) begin
      cur_name = $sformatf("vec%0d", i);
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, 1);
      wait_valid(tv[i].lat);
      start = 0;
      tick();
      check("valid_one_cycle", {31'd0, result_valid}, 32'd0);
      check("result_hold", result, tv[i].exp);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      last_exp = tv[i].exp;
    end
    cur_name = "flush";
    issue(MD_DIV, 32'd100, 32'd7, 32'd0, 0);
    repeat (10) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    check("flush_result_kept", result, last_exp);
    cur_name = "mul_after_flush";
    issue(MD_MUL, 32'd3, 32'd4, 32'd12, 1);
    wait_valid(34);
    start = 0;
    tick();
    cur_name = "reset_mid_calc";
    issue(MD_MULHU, 32'hDEADBEEF, 32'h12345678, 32'd0, 0);
    repeat (5) tick();
    reset = 1;
    start = 0;
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 0;
    tick();
    cur_name = "back_to_back";
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1);
    wait_valid(34);
    issue(MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1);
    check("b2b_stall_in_done", {31'd0, stall}, 32'd0);
    tick();
    check("b2b_accept_busy", {31'd0, busy}, 32'd0);
    check("b2b_accept_stall", {31'd0, stall}, 32'd1);
    wait_valid(34);
    start = 0;
    tick();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
